display_scheduler: RTL
======================

DISPLAY_SCHEDULER -- requirements
Module: display_scheduler

Interface
REQ-001 Parameter DWELL, default 50000000, SHALL be the number of cycles one requester owns the display per turn (legal range 2..2^32-1).
REQ-002 Parameter GAP, default 5000, SHALL be the number of blank cycles between owners (legal range 1..2^16-1).
REQ-003 Port clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 Port reset  input  1  SHALL be an asynchronous, active-low reset.
REQ-005 Port req  input  4  SHALL carry one request per requester; bit i is requester i.
REQ-006 Port data  input  64  SHALL carry the requester values; requester i uses bits [16i+15:16i].
REQ-007 Port hold  input  1  SHALL, when high, freeze the dwell counter.
REQ-008 Port grant  output  4  SHALL be the one-hot grant for the current owner, or 0 when there is no owner.
REQ-009 Port disp_on  output  1  SHALL be the enable to the 7-segment scan driver.
REQ-010 Port disp_number  output  16  SHALL be the value shown, 4 hex digits, MSB digit leftmost.
REQ-011 Port turn_done  output  1  SHALL pulse for one cycle when an owner's turn ends for any reason.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, SHOW and GAP.
REQ-013 IDLE: grant=0 and disp_on=0; when req!=0 the FSM SHALL go to SHOW on the next edge, granting the round-robin winner.
REQ-014 Round-robin SHALL search starting at last_owner+1 mod 4 and pick the first set req bit; last_owner resets to 3, so requester 0 wins first.
REQ-015 SHOW: grant is one-hot for the owner, disp_on=1, and disp_number is registered from the owner's data slice (1-cycle latency, tracked live every cycle).
REQ-016 SHOW: the dwell counter SHALL increment each cycle unless hold=1; at count DWELL-1 with hold=0, the FSM SHALL go to GAP.
REQ-017 SHOW: if the owner's req drops, the FSM SHALL go to GAP on the next edge regardless of the count.
REQ-018 Every SHOW-to-GAP transition SHALL assert turn_done for exactly the first GAP cycle and update last_owner.
REQ-019 GAP: grant=0, disp_on=0, disp_number held; after GAP cycles the FSM SHALL go to SHOW if req!=0 (new arbitration), else to IDLE.
REQ-020 If only the previous owner still requests at the end of GAP, it SHALL be re-granted (no starvation, no deadlock).
REQ-021 Changes to req during GAP SHALL be sampled only at the end of GAP.
REQ-022 If hold=1 and the owner's req drops in the same cycle, the request drop SHALL win (REQ-017).
REQ-023 The counters SHALL be sized for DWELL and GAP and SHALL never wrap; each SHALL clear on every state entry.

Reset
REQ-024 During reset: state=IDLE, grant=0, disp_on=0, disp_number=16'h0000, turn_done=0, counters=0, last_owner=3.
REQ-025 Reset asserted mid-SHOW or mid-GAP SHALL drop all outputs to the REQ-024 values immediately, without waiting for clk.
REQ-026 After reset deasserts, the first grant SHALL follow REQ-013/REQ-014 from the reset state.

Structure
REQ-027 The state encoding (IDLE=0, SHOW=1, GAP=2), NREQ=4 and DIGIT_W=16 SHALL live in a shared package display_pkg.
REQ-028 The arbiter SHALL be one sub-module, rr_arbiter4: inputs req[3:0] and last_owner[1:0]; outputs winner[1:0] and valid; purely combinational.
REQ-029 disp_on and disp_number SHALL connect directly to the existing scan driver's on/number inputs; no scan logic SHALL be duplicated here.

Verification (DWELL=8, GAP=2)
REQ-030 Stimulus: req=0001, data[15:0]=16'h1234. Response: grant=0001 one cycle after req rises; disp_number=16'h1234; 8 SHOW cycles, then 2 GAP cycles with disp_on=0; then grant=0001 again.
REQ-031 Stimulus: req=1111. Response: grant order 0001,0010,0100,1000,0001; turn_done pulses every 10 cycles.
REQ-032 Stimulus: owner 0 drops req in its 3rd SHOW cycle, req[2] set. Response: GAP on the next edge, turn_done=1, then grant=0100.
REQ-033 Stimulus: hold=1 for 20 cycles during SHOW. Response: grant stays constant; the turn ends 8 counted cycles after hold falls.
REQ-034 Stimulus: reset pulled low mid-SHOW asynchronously. Response: grant=0 and disp_on=0 before the next clk edge; after release, requester 0 is granted first.
REQ-035 Stimulus: data slice of the owner changes to 16'hBEEF during SHOW. Response: disp_number=16'hBEEF one cycle later.

Source files
------------

// File: rtl/display_pkg.sv
// Shared types and constants for the display scheduler and its round-robin arbiter.
package display_pkg;

    localparam int unsigned NREQ    = 4;
    localparam int unsigned DIGIT_W = 16;
    localparam int unsigned DATA_W  = NREQ * DIGIT_W;
    localparam int unsigned OWNER_W = 2;
    localparam int unsigned DWELL_W = 32;
    localparam int unsigned GAP_W   = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SHOW = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    // Extract requester i's 16-bit value from the packed data bus.
    function automatic logic [DIGIT_W-1:0] digit_slice(input logic [DATA_W-1:0] d,
                                                        input logic [OWNER_W-1:0] i);
        return d[{i, 4'b0000} +: DIGIT_W];
    endfunction

    function automatic logic [NREQ-1:0] onehot(input logic [OWNER_W-1:0] i);
        return NREQ'(1) << i;
    endfunction

endpackage

// File: rtl/rr_arbiter4.sv
// Combinational 4-way round-robin arbiter; search starts just after last_owner.
module rr_arbiter4
    import display_pkg::*;
(
    input  logic [NREQ-1:0]    req,
    input  logic [OWNER_W-1:0] last_owner,
    output logic [OWNER_W-1:0] winner,
    output logic               valid
);

    logic [OWNER_W-1:0] idx;

    // Walk from farthest to nearest candidate so the nearest set bit wins.
    always_comb begin
        winner = last_owner;
        idx    = last_owner;
        valid  = |req;
        for (int k = 4; k >= 1; k--) begin
            idx = last_owner + OWNER_W'(k);
            if (req[idx]) begin
                winner = idx;
            end
        end
    end

endmodule

// File: rtl/display_scheduler.sv
// Time-shares a 4-digit hex display among four requesters with a dwell period
// per owner and a blank gap between owners.
module display_scheduler
    import display_pkg::*;
#(
    parameter int unsigned DWELL = 50000000,
    parameter int unsigned GAP   = 5000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NREQ-1:0]    req,
    input  logic [DATA_W-1:0]  data,
    input  logic               hold,
    output logic [NREQ-1:0]    grant,
    output logic               disp_on,
    output logic [DIGIT_W-1:0] disp_number,
    output logic               turn_done
);

    state_t             state_q, state_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic [GAP_W-1:0]   gap_q, gap_d;
    logic [OWNER_W-1:0] owner_q, owner_d;
    logic [OWNER_W-1:0] last_q, last_d;
    logic [OWNER_W-1:0] arb_winner;
    logic               arb_valid;

    logic [NREQ-1:0]    grant_d;
    logic               disp_on_d;
    logic [DIGIT_W-1:0] number_d;
    logic               turn_done_d;

    rr_arbiter4 u_arb (
        .req        (req),
        .last_owner (last_q),
        .winner     (arb_winner),
        .valid      (arb_valid)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            dwell_q     <= '0;
            gap_q       <= '0;
            owner_q     <= '0;
            last_q      <= 2'd3;
            grant       <= '0;
            disp_on     <= 1'b0;
            disp_number <= '0;
            turn_done   <= 1'b0;
        end else begin
            state_q     <= state_d;
            dwell_q     <= dwell_d;
            gap_q       <= gap_d;
            owner_q     <= owner_d;
            last_q      <= last_d;
            grant       <= grant_d;
            disp_on     <= disp_on_d;
            disp_number <= number_d;
            turn_done   <= turn_done_d;
        end
    end

    // Next state; counters clear on every state entry.
    always_comb begin
        state_d = state_q;
        dwell_d = dwell_q;
        gap_d   = gap_q;
        owner_d = owner_q;
        last_d  = last_q;
        unique case (state_q)
            ST_IDLE: begin
                if (arb_valid) begin
                    state_d = ST_SHOW;
                    owner_d = arb_winner;
                    dwell_d = '0;
                    gap_d   = '0;
                end
            end
            ST_SHOW: begin
                // A dropped request ends the turn even while hold is asserted.
                if (!req[owner_q] || (!hold && dwell_q == DWELL_W'(DWELL - 1))) begin
                    state_d = ST_GAP;
                    gap_d   = '0;
                    dwell_d = '0;
                    last_d  = owner_q;
                end else if (!hold) begin
                    dwell_d = dwell_q + DWELL_W'(1);
                end
            end
            ST_GAP: begin
                if (gap_q == GAP_W'(GAP - 1)) begin
                    gap_d   = '0;
                    dwell_d = '0;
                    if (arb_valid) begin
                        state_d = ST_SHOW;
                        owner_d = arb_winner;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    gap_d = gap_q + GAP_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                dwell_d = '0;
                gap_d   = '0;
            end
        endcase
    end

    // Next values of the registered display outputs.
    always_comb begin
        grant_d     = '0;
        disp_on_d   = 1'b0;
        number_d    = disp_number;
        turn_done_d = 1'b0;
        if (state_d == ST_SHOW) begin
            grant_d   = onehot(owner_d);
            disp_on_d = 1'b1;
            number_d  = digit_slice(data, owner_d);
        end
        if (state_q == ST_SHOW && state_d == ST_GAP) begin
            turn_done_d = 1'b1;
        end
    end

endmodule
